// File: rtl/sqrt_vector_sequencer_if.sv
// Handshake bundle between the vector sequencer and the 8-bit square-root core.
// The master side issues operands and St; the slave side answers with Done and Sqrt.
interface sqrt_vector_sequencer_if;
  logic [7:0] N;
  logic       St;
  logic       Done;
  logic [3:0] Sqrt;

  modport master (output N, output St, input Done, input Sqrt);
  modport slave  (input N, input St, output Done, output Sqrt);
endinterface

// File: rtl/sqrt_vector_sequencer.sv
// Feeds a loadable bank of operands to the sqrt core over St/Done and captures each root
// into a readable result bank; flags a core that stops handshaking.
//
// state   | meaning
// IDLE    | waiting for run, vector bank writable
// ISSUE   | present operand, wait for core to drop Done
// ASSERT  | St high, wait for Done
// RELEASE | St low, wait for core to drop Done
// NEXT    | advance index or finish the pass
// FINISH  | pass complete, all_done held, bank writable
// ERROR   | handshake timeout, err held, bank writable
module sqrt_vector_sequencer #(
  parameter int NUM_VECTORS = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        load_en,
  input  logic [3:0]                  load_addr,
  input  logic [7:0]                  load_data,
  input  logic                        run,
  sqrt_vector_sequencer_if.master     core,
  input  logic [3:0]                  res_addr,
  output logic [3:0]                  res_data,
  output logic                        busy,
  output logic                        all_done,
  output logic                        err,
  output logic [3:0]                  cur_idx
);

  localparam int         WW        = $clog2(TIMEOUT + 1);
  localparam logic [3:0] ADDR_MASK = 4'(NUM_VECTORS - 1);
  localparam logic [3:0] LAST_IDX  = 4'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ASSERT, S_RELEASE, S_NEXT, S_FINISH, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [7:0]      n_q, n_d;
  logic            st_q, st_d;
  logic            busy_q, busy_d;
  logic            all_done_q, all_done_d;
  logic            err_q, err_d;
  logic [7:0]      vec_q [NUM_VECTORS];
  logic [7:0]      vec_d [NUM_VECTORS];
  logic [3:0]      res_q [NUM_VECTORS];
  logic [3:0]      res_d [NUM_VECTORS];

  logic load_ok, res_ok, timed_out, in_wait;

  // Power-of-two bank: any address bit above the index range marks it out of range.
  assign load_ok   = (load_addr & ~ADDR_MASK) == 4'd0;
  assign res_ok    = (res_addr  & ~ADDR_MASK) == 4'd0;
  assign timed_out = (wait_q == WW'(TIMEOUT));
  assign in_wait   = (state_q == S_ISSUE) || (state_q == S_ASSERT) || (state_q == S_RELEASE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    n_d        = n_q;
    st_d       = 1'b0;
    busy_d     = busy_q;
    all_done_d = all_done_q;
    err_d      = err_q;
    vec_d      = vec_q;
    res_d      = res_q;

    case (state_q)
      S_IDLE, S_FINISH, S_ERROR: begin
        if (run) begin
          idx_d      = 4'd0;
          all_done_d = 1'b0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_ISSUE;
        end else if (load_en && load_ok) begin
          vec_d[load_addr] = load_data;
        end
      end
      S_ISSUE: begin
        n_d = vec_q[idx_q];
        if (!core.Done)     state_d = S_ASSERT;
        else if (timed_out) state_d = S_ERROR;
      end
      S_ASSERT: begin
        if (core.Done) begin
          res_d[idx_q] = core.Sqrt;
          state_d      = S_RELEASE;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          st_d = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!core.Done)     state_d = S_NEXT;
        else if (timed_out) state_d = S_ERROR;
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          all_done_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_FINISH;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_ERROR) && (state_q != S_ERROR)) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end

    if (state_d != state_q) wait_d = '0;
    else if (in_wait)       wait_d = wait_q + WW'(1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      wait_q     <= '0;
      n_q        <= 8'd0;
      st_q       <= 1'b0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_VECTORS; i++) begin
        vec_q[i] <= 8'd0;
        res_q[i] <= 4'd0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      n_q        <= n_d;
      st_q       <= st_d;
      busy_q     <= busy_d;
      all_done_q <= all_done_d;
      err_q      <= err_d;
      vec_q      <= vec_d;
      res_q      <= res_d;
    end
  end

  assign core.N   = n_q;
  assign core.St  = st_q;
  assign res_data = res_ok ? res_q[res_addr] : 4'd0;
  assign busy     = busy_q;
  assign all_done = all_done_q;
  assign err      = err_q;
  assign cur_idx  = idx_q;

endmodule

// File: tb/tb_sqrt_vector_sequencer.sv
// Bench for sqrt_vector_sequencer: behavioural sqrt core plus a queue-based scoreboard
// whose monitor checks every pushed expectation on the falling clock edge.
module tb_sqrt_vector_sequencer;

  localparam int TIMEOUT = 255;
  localparam int CORE_K  = 5;

  logic       clk;
  logic       resetN;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       run;
  logic [3:0] res_addr;
  logic [3:0] res_data;
  logic       busy, all_done, err;
  logic [3:0] cur_idx;

  sqrt_vector_sequencer_if bus();

  sqrt_vector_sequencer #(.NUM_VECTORS(16), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .run       (run),
    .core      (bus),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .busy      (busy),
    .all_done  (all_done),
    .err       (err),
    .cur_idx   (cur_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural sqrt core ----------------
  int         hang_at;
  logic       stuck_done;
  logic       core_done;
  logic [3:0] core_sqrt;
  int         core_cnt;

  function automatic logic [3:0] isqrt(input logic [7:0] n);
    for (int r = 15; r >= 0; r--)
      if (r * r <= int'(n)) return 4'(r);
    return 4'd0;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      core_done <= 1'b0;
      core_sqrt <= 4'd0;
      core_cnt  <= 0;
    end else if (bus.St && !core_done && (hang_at != int'(cur_idx))) begin
      if (core_cnt == CORE_K - 1) begin
        core_done <= 1'b1;
        core_sqrt <= isqrt(bus.N);
        core_cnt  <= 0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end else if (!bus.St && core_done) begin
      core_done <= 1'b0;
    end
  end

  assign bus.Done = core_done | stuck_done;
  assign bus.Sqrt = core_sqrt;

  // ---------------- protocol observers ----------------
  int   viol;
  int   hang_st_cycles;
  logic st_prev;

  initial begin
    viol = 0;
    hang_st_cycles = 0;
    st_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.St && ((!st_prev && bus.Done) || stuck_done)) viol++;
    if (bus.St && (hang_at >= 0) && (int'(cur_idx) == hang_at)) hang_st_cycles++;
    st_prev = bus.St;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string nm;
    int    sel;
    int    exp;
  } chk_t;

  chk_t scb_q[$];
  int   total;
  int   bad;

  function automatic int sig(input int sel);
    case (sel)
      0: return int'(res_data);
      1: return int'(busy);
      2: return int'(all_done);
      3: return int'(err);
      4: return int'(bus.St);
      5: return int'(cur_idx);
      6: return int'(bus.N);
      7: return hang_st_cycles;
      8: return viol;
      default: return -1;
    endcase
  endfunction

  initial begin
    total = 0;
    bad   = 0;
  end

  always @(negedge clk) begin
    chk_t c;
    int   got;
    while (scb_q.size() != 0) begin
      c   = scb_q.pop_front();
      got = sig(c.sel);
      total++;
      if (got != c.exp) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", c.nm, got, c.exp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input int sel, input int exp);
    chk_t c;
    c.nm  = nm;
    c.sel = sel;
    c.exp = exp;
    scb_q.push_back(c);
  endtask

  task automatic read_chk(input string nm, input int addr, input int exp);
    res_addr = 4'(addr);
    expect_v(nm, 0, exp);
    tick(1);
  endtask

  task automatic load_vec(input int addr, input int data);
    load_en   = 1'b1;
    load_addr = 4'(addr);
    load_data = 8'(data);
    tick(1);
    load_en   = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  // Bounded wait; the trailing expectation fails if the bound expired first.
  task automatic wait_for(input string nm, input int sel, input int val, input int bound);
    int n;
    n = 0;
    while ((sig(sel) != val) && (n < bound)) begin
      tick(1);
      n++;
    end
    expect_v(nm, sel, val);
  endtask

  int init_vec [16] = '{0, 1, 4, 9, 16, 25, 36, 49, 64, 81, 100, 121, 144, 169, 196, 255};
  int exp_p1   [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
  int exp_p2   [16] = '{15, 14, 13, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};

  initial begin
    int n;
    resetN = 1'b1;
    load_en = 1'b0; load_addr = 4'd0; load_data = 8'd0;
    run = 1'b0; res_addr = 4'd0;
    hang_at = -1; stuck_done = 1'b0;
    #2 resetN = 1'b0;

    // reset state, clock running
    tick(3);
    expect_v("rst_busy", 1, 0);
    expect_v("rst_all_done", 2, 0);
    expect_v("rst_err", 3, 0);
    expect_v("rst_st", 4, 0);
    expect_v("rst_cur_idx", 5, 0);
    expect_v("rst_n", 6, 0);
    tick(2);
    resetN = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) read_chk($sformatf("rst_res%0d", i), i, 0);

    // pass 1: perfect squares, with an illegal load while busy
    for (int i = 0; i < 16; i++) load_vec(i, init_vec[i]);
    pulse_run();
    expect_v("p1_busy_after_run", 1, 1);
    load_en = 1'b1; load_addr = 4'd2; load_data = 8'hFF;
    tick(3);
    load_en = 1'b0;
    wait_for("p1_all_done", 2, 1, 400);
    total++;
    if (all_done !== 1'b1) begin
      bad++;
      $display("FAIL p1_all_done_direct: got %0b expected 1", all_done);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL p1_busy_direct: got %0b expected 0", busy);
    end
    expect_v("p1_busy_low", 1, 0);
    expect_v("p1_err_low", 3, 0);
    tick(1);
    for (int i = 0; i < 16; i++) read_chk($sformatf("p1_res%0d", i), i, exp_p1[i]);
    expect_v("p1_no_st_with_done", 8, 0);
    tick(1);

    // pass 2: core hangs on vector 3
    load_vec(0, 225);
    load_vec(1, 196);
    load_vec(2, 169);
    hang_at = 3;
    pulse_run();
    wait_for("to_err", 3, 1, 700);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL to_err_direct: got %0b expected 1", err);
    end
    total++;
    if (cur_idx !== 4'd3) begin
      bad++;
      $display("FAIL to_cur_idx_direct: got %0d expected 3", cur_idx);
    end
    total++;
    if (bus.St !== 1'b0) begin
      bad++;
      $display("FAIL to_st_direct: got %0b expected 0", bus.St);
    end
    expect_v("to_st_low", 4, 0);
    expect_v("to_busy_low", 1, 0);
    expect_v("to_all_done_low", 2, 0);
    expect_v("to_cur_idx", 5, 3);
    expect_v("to_st_high_cycles", 7, TIMEOUT);
    tick(1);
    hang_at = -1;
    for (int i = 0; i < 16; i++) read_chk($sformatf("to_res%0d", i), i, exp_p2[i]);

    // pass 3: Done left high; run wins over a same-cycle load
    stuck_done = 1'b1;
    load_en = 1'b1; load_addr = 4'd3; load_data = 8'd0;
    pulse_run();
    load_en = 1'b0;
    tick(9);
    expect_v("stuck_busy", 1, 1);
    expect_v("stuck_st_low", 4, 0);
    expect_v("stuck_cur_idx", 5, 0);
    expect_v("stuck_n", 6, 225);
    tick(1);
    stuck_done = 1'b0;
    wait_for("p3_all_done", 2, 1, 400);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL p3_err_direct: got %0b expected 0", err);
    end
    expect_v("p3_err_low", 3, 0);
    expect_v("p3_no_st_with_done", 8, 0);
    tick(1);
    for (int i = 0; i < 16; i++) read_chk($sformatf("p3_res%0d", i), i, exp_p2[i]);

    // pass 4: reset while in ASSERT at index 7
    pulse_run();
    n = 0;
    while (!((cur_idx == 4'd7) && bus.St) && (n < 300)) begin
      tick(1);
      n++;
    end
    expect_v("mid_cur_idx", 5, 7);
    expect_v("mid_st", 4, 1);
    @(negedge clk);
    #1;
    resetN = 1'b0;
    expect_v("mid_rst_st", 4, 0);
    expect_v("mid_rst_busy", 1, 0);
    tick(2);
    resetN = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) read_chk($sformatf("mid_res%0d", i), i, 0);
    pulse_run();
    wait_for("p4_all_done", 2, 1, 400);
    expect_v("p4_err_low", 3, 0);
    tick(1);
    read_chk("p4_res0", 0, 0);
    read_chk("p4_res15", 15, 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if ((bad == 0) && (total >= 12)) $display("PASS");
    else $display("FAIL summary: got bad=%0d total=%0d expected bad=0", bad, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sqrt_vector_sequencer.md
# sqrt_vector_sequencer

Upstream driver for the 8-bit square-root core. It holds a loadable bank of input vectors and feeds them one at a time to the core using its St/Done handshake. Each 4-bit root is captured into a readable result bank. It replaces bench-side stimulus in on-board runs and flags a core that stops handshaking.

## Interface
- NUM_VECTORS, 16, number of vector/result entries (power of two, ≤16)
- TIMEOUT, 255, maximum cycles allowed in any wait state before error
- clk  in  1  system clock, rising-edge
- resetN  in  1  asynchronous active-low reset
- load_en  in  1  write vector bank when idle
- load_addr  in  4  vector write index
- load_data  in  8  vector write value
- run  in  1  start a pass over all vectors (sampled in IDLE/FINISH/ERROR)
- N  out  8  operand to sqrt core, registered
- St  out  1  start request to sqrt core, registered
- Done  in  1  completion flag from sqrt core
- Sqrt  in  4  result from sqrt core
- res_addr  in  4  result read index
- res_data  out  4  result bank[res_addr], combinational read
- busy  out  1  pass in progress
- all_done  out  1  pass completed; held until next run
- err  out  1  handshake timeout; held until next run
- cur_idx  out  4  index being processed

## Operation
- States: IDLE, ISSUE, ASSERT, RELEASE, NEXT, FINISH, ERROR.
- IDLE/FINISH/ERROR:
  - St=0, busy=0.
  - load_en=1 writes vec[load_addr]=load_data; writes are ignored in every other state.
  - run=1 → idx=0, all_done=0, err=0, busy=1, go to ISSUE.
  - run takes priority over load_en in the same cycle; the load is dropped.
- ISSUE: N←vec[idx]. If Done=0, go to ASSERT; otherwise wait here, because the core has not yet released.
- ASSERT: St=1, N held. On Done=1, res[idx]←Sqrt and go to RELEASE.
- RELEASE: St=0, N held. On Done=0, go to NEXT.
- NEXT: if idx==NUM_VECTORS-1, go to FINISH and set all_done=1; else idx+1 and go to ISSUE.
- Timeout:
  - wait_cnt clears on every state change and increments each cycle spent in ISSUE, ASSERT or RELEASE.
  - At wait_cnt==TIMEOUT, go to ERROR: err=1, St=0, busy=0.
  - idx freezes, so cur_idx reports the failing entry.
- A result entry is written only in ASSERT on Done=1. Entries not reached keep their previous values.
- load_addr and res_addr ≥ NUM_VECTORS: writes are ignored and reads return 0.

## Timing
- Reset (async, resetN=0) sets:
  - outputs: N=0, St=0, busy=0, all_done=0, err=0, cur_idx=0
  - internals: state=IDLE, wait_cnt=0
  - banks: all vec and res entries cleared to 0
- Exit from reset is synchronous to the first rising edge with resetN=1.
- run sampled at edge t → busy=1 and state=ISSUE after edge t. N valid after edge t+1, St=1 after edge t+2.
- N is stable at least one full cycle before St rises and stays stable until St falls.
- Done seen high at edge d → result written at edge d and St=0 after edge d.
- Per-vector overhead beyond the core's handshake: 3 cycles (ISSUE, RELEASE exit, NEXT).
- Full pass with a core answering Done k cycles after St and releasing 1 cycle after St falls: about NUM_VECTORS×(k+4) cycles.
- A reset mid-pass aborts immediately, drops St, and clears both banks.
- Done glitching high in ASSERT for one cycle counts as completion; no filtering.

## Test plan
- Reset with clk running:
  - all outputs are 0 throughout resetN=0
  - after release, res_data=0 for every res_addr.
- Load vec[i] = 0,1,4,9,16,25,36,49,64,81,100,121,144,169,196,255 and pulse run, using a behavioural core with Done 5 cycles after St:
  - res = 0..14 plus 15 for 255
  - all_done=1 with busy=0
  - St never high while Done high at ISSUE exit.
- Core holds Done=0 forever after vector 3 issues:
  - err=1 after TIMEOUT+1 cycles in ASSERT, St=0, cur_idx=3
  - res[0..2] valid, res[3..15] unchanged.
- Drive load_en with addr 2, data 0xFF during the busy pass → vec[2] unchanged; the next run gives res[2]=2 for input 4.
- Assert resetN=0 while in ASSERT at idx 7 → St and busy drop within the same cycle and both banks read 0 afterwards.
- Core leaves Done=1 from the previous pass when run is pulsed → the sequencer waits in ISSUE, St stays 0 until Done falls, then proceeds normally.
